// File: rtl/mem_responder.sv
// mem_responder: word-array memory model answering mem_read/mem_write requests
// after a fixed, parameterised latency. Writes commit on the cycle after the
// response pulse; reads return the word as it was when the request was accepted.
module mem_responder #(
    parameter int unsigned DEPTH   = 256,  // words; power of two, at least 2
    parameter int unsigned LATENCY = 3     // 1..15 cycles, acceptance to mem_resp
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [31:0] mem_address,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_byte_enable,
    output logic        mem_resp,
    output logic [31:0] mem_rdata,
    output logic        proto_err
);

    localparam int unsigned IdxW = $clog2(DEPTH);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StWait = 2'd1;
    localparam logic [1:0] StResp = 2'd2;

    // Counter starts at LATENCY-1; WAIT exits when it reads 1, so the
    // response lands exactly LATENCY cycles after the request is first seen.
    localparam logic [3:0] CntInit = 4'(LATENCY - 1);
    localparam bit         SkipWait = (LATENCY <= 1);

    logic [1:0]      state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;
    logic [IdxW-1:0] idx_q, idx_d;
    logic [31:0]     wdata_q, wdata_d;
    logic [3:0]      be_q, be_d;
    logic            op_rd_q, op_rd_d;
    logic            op_wr_q, op_wr_d;
    logic [31:0]     rdata_q, rdata_d;
    logic            perr_q, perr_d;

    logic [31:0]     mem_q [DEPTH];
    logic [31:0]     mem_d [DEPTH];

    logic [IdxW-1:0] req_idx;
    logic            req;
    logic            commit;
    logic            unused_addr;

    // Addresses wrap modulo DEPTH words; byte offset and upper bits are dropped.
    assign req_idx     = mem_address[IdxW+1:2];
    assign req         = mem_read | mem_write;
    assign unused_addr = ^{mem_address[31:IdxW+2], mem_address[1:0]};

    // Write commit happens on the edge that leaves RESP.
    assign commit = (state_q == StResp) && op_wr_q;

    // Transaction FSM and request latching.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        wdata_d = wdata_q;
        be_d    = be_q;
        op_rd_d = op_rd_q;
        op_wr_d = op_wr_q;
        rdata_d = rdata_q;
        perr_d  = perr_q;
        case (state_q)
            StIdle: begin
                if (req) begin
                    idx_d   = req_idx;
                    wdata_d = mem_wdata;
                    be_d    = mem_byte_enable;
                    op_rd_d = mem_read;
                    op_wr_d = mem_write;
                    // Pre-write contents, so a read+write returns the old word.
                    rdata_d = mem_q[req_idx];
                    cnt_d   = CntInit;
                    perr_d  = perr_q | (mem_read & mem_write);
                    state_d = SkipWait ? StResp : StWait;
                end
            end
            StWait: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = StResp;
                end
            end
            StResp: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Storage next-state: byte-masked merge of the latched write data.
    always_comb begin
        mem_d = mem_q;
        if (commit) begin
            for (int b = 0; b < 4; b++) begin
                if (be_q[b]) begin
                    mem_d[idx_q][8*b +: 8] = wdata_q[8*b +: 8];
                end
            end
        end
    end

    // Control and latched-request registers; reset aborts any transaction.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            idx_q   <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            op_rd_q <= 1'b0;
            op_wr_q <= 1'b0;
            rdata_q <= '0;
            perr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
            op_rd_q <= op_rd_d;
            op_wr_q <= op_wr_d;
            rdata_q <= rdata_d;
            perr_q  <= perr_d;
        end
    end

    // Storage array; cleared in full on reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            mem_q <= mem_d;
        end
    end

    // Outputs: rdata is forced to zero except on a read's response cycle.
    always_comb begin
        mem_resp  = (state_q == StResp);
        mem_rdata = (mem_resp && op_rd_q) ? rdata_q : 32'h0;
        proto_err = perr_q;
    end

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: two instances (LATENCY=3 and LATENCY=1) driven by
// directed scenarios and random transactions, checked against an array model.
module tb_mem_responder;

    localparam int DEPTH = 256;
    localparam int LAT_A = 3;
    localparam int LAT_B = 1;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  rd, wr, resp, perr;
    logic [31:0] addr [2];
    logic [31:0] wdat [2];
    logic [31:0] rdat [2];
    logic [3:0]  be   [2];

    int total = 0;
    int bad   = 0;

    // Reference model: one word array and one sticky error flag per instance.
    logic [31:0] mdl [2][DEPTH];
    logic        mdl_err [2];

    always #5 clk = ~clk;

    mem_responder #(.DEPTH(DEPTH), .LATENCY(LAT_A)) dut_a (
        .clk             (clk),
        .rst             (rst),
        .mem_read        (rd[0]),
        .mem_write       (wr[0]),
        .mem_address     (addr[0]),
        .mem_wdata       (wdat[0]),
        .mem_byte_enable (be[0]),
        .mem_resp        (resp[0]),
        .mem_rdata       (rdat[0]),
        .proto_err       (perr[0])
    );

    mem_responder #(.DEPTH(DEPTH), .LATENCY(LAT_B)) dut_b (
        .clk             (clk),
        .rst             (rst),
        .mem_read        (rd[1]),
        .mem_write       (wr[1]),
        .mem_address     (addr[1]),
        .mem_wdata       (wdat[1]),
        .mem_byte_enable (be[1]),
        .mem_resp        (resp[1]),
        .mem_rdata       (rdat[1]),
        .proto_err       (perr[1])
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int s = 0; s < 2; s++) begin
            for (int i = 0; i < DEPTH; i++) mdl[s][i] = 32'h0;
            mdl_err[s] = 1'b0;
        end
    endtask

    // One full request/response on instance s; got returns the response rdata.
    task automatic xact(input int s, input bit r, input bit w, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] bemask, input string tag,
                        output logic [31:0] got);
        int          idx;
        int          lat;
        int          seen;
        logic [31:0] exp_rd;
        idx    = int'((a >> 2) % DEPTH);
        lat    = (s == 0) ? LAT_A : LAT_B;
        seen   = -1;
        exp_rd = r ? mdl[s][idx] : 32'h0;
        got    = 32'hx;
        @(negedge clk);
        rd[s] = r; wr[s] = w; addr[s] = a; wdat[s] = d; be[s] = bemask;
        for (int c = 1; c <= 20 && seen < 0; c++) begin
            @(posedge clk); #1;
            if (resp[s]) begin
                seen = c;
                got  = rdat[s];
            end else begin
                check({tag, " rdata_idle"}, rdat[s], 32'h0);
            end
        end
        rd[s] = 1'b0; wr[s] = 1'b0;
        check({tag, " latency"}, seen, lat);
        check({tag, " rdata"}, got, exp_rd);
        if (w) begin
            for (int b = 0; b < 4; b++)
                if (bemask[b]) mdl[s][idx][8*b +: 8] = d[8*b +: 8];
        end
        if (r && w) mdl_err[s] = 1'b1;
        @(posedge clk); #1;
        check({tag, " resp_single"}, {31'h0, resp[s]}, 32'h0);
        check({tag, " rdata_after"}, rdat[s], 32'h0);
        check({tag, " proto_err"}, {31'h0, perr[s]}, {31'h0, mdl_err[s]});
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] got;
        int          op;
        rst = 1'b1;
        rd = '0; wr = '0;
        for (int s = 0; s < 2; s++) begin
            addr[s] = '0; wdat[s] = '0; be[s] = '0;
        end
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        for (int s = 0; s < 2; s++) begin
            check("reset resp", {31'h0, resp[s]}, 32'h0);
            check("reset rdata", rdat[s], 32'h0);
            check("reset proto_err", {31'h0, perr[s]}, 32'h0);
        end
        @(negedge clk);
        rst = 1'b0;

        // Full-word write then read back.
        xact(0, 0, 1, 32'h40, 32'hDEADBEEF, 4'hF, "wr40", got);
        xact(0, 1, 0, 32'h40, 32'h0, 4'h0, "rd40", got);
        check("rd40 const", got, 32'hDEADBEEF);

        // Partial byte-enable merge.
        xact(0, 0, 1, 32'h40, 32'h11223344, 4'b0101, "wr40_be", got);
        xact(0, 1, 0, 32'h40, 32'h0, 4'h0, "rd40_be", got);
        check("rd40_be const", got, 32'hDE22BE44);

        // Zero byte-enable leaves storage alone.
        xact(0, 0, 1, 32'h40, 32'h99999999, 4'b0000, "wr40_be0", got);
        xact(0, 1, 0, 32'h40, 32'h0, 4'h0, "rd40_be0", got);
        check("rd40_be0 const", got, 32'hDE22BE44);

        // Address wrap and ignored byte offset.
        xact(0, 0, 1, 32'h404, 32'hA5A5A5A5, 4'hF, "wr404", got);
        xact(0, 1, 0, 32'h004, 32'h0, 4'h0, "rd004", got);
        check("rd004 wrap", got, 32'hA5A5A5A5);
        xact(0, 1, 0, 32'h006, 32'h0, 4'h0, "rd006", got);
        check("rd006 offset", got, 32'hA5A5A5A5);

        // Simultaneous read+write: old data, sticky error, write committed.
        xact(0, 1, 1, 32'h80, 32'h5, 4'hF, "rw80", got);
        check("rw80 old", got, 32'h0);
        check("rw80 perr", {31'h0, perr[0]}, 32'h1);
        xact(0, 1, 0, 32'h80, 32'h0, 4'h0, "rd80", got);
        check("rd80 const", got, 32'h5);
        check("rd80 perr sticky", {31'h0, perr[0]}, 32'h1);

        // Reset during WAIT aborts the write and clears the error flag.
        @(negedge clk);
        wr[0] = 1'b1; addr[0] = 32'h10; wdat[0] = 32'h77; be[0] = 4'hF;
        @(posedge clk); #1;
        check("abort pre resp", {31'h0, resp[0]}, 32'h0);
        @(negedge clk);
        rst = 1'b1; wr[0] = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        model_clear();
        check("abort perr cleared", {31'h0, perr[0]}, 32'h0);
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            check("abort no resp", {31'h0, resp[0]}, 32'h0);
        end
        xact(0, 1, 0, 32'h10, 32'h0, 4'h0, "rd10_abort", got);
        check("rd10 const", got, 32'h0);
        xact(0, 1, 0, 32'h40, 32'h0, 4'h0, "rd40_cleared", got);
        check("rd40 cleared", got, 32'h0);

        // LATENCY=1 with read held high: response on every odd cycle.
        xact(1, 0, 1, 32'h8, 32'hCAFEF00D, 4'hF, "b_wr8", got);
        @(negedge clk);
        rd[1] = 1'b1; addr[1] = 32'h8;
        for (int c = 1; c <= 8; c++) begin
            @(posedge clk); #1;
            check("b_held resp", {31'h0, resp[1]}, {31'h0, 1'(c % 2)});
            check("b_held rdata", rdat[1], (c % 2 == 1) ? 32'hCAFEF00D : 32'h0);
        end
        rd[1] = 1'b0;
        @(posedge clk); #1;
        check("b_held stop", {31'h0, resp[1]}, 32'h0);

        // Random traffic on both instances; narrow address range forces reuse.
        for (int n = 0; n < 60; n++) begin
            op = int'($urandom_range(0, 5));
            xact(int'($urandom_range(0, 1)),
                 (op != 1 && op != 2), (op == 1 || op == 2 || op == 5),
                 {$urandom_range(0, 7), 2'b00, 6'h0, $urandom_range(0, 15) << 2}
                     | ($urandom_range(0, 1) << 12),
                 $urandom, 4'($urandom_range(0, 15)), "rand", got);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Memory-side responder for the CPU's mem_read/mem_write/mem_resp interface: it answers the requests the datapath issues when loading its registers.
- Backed by an internal word array with configurable response latency.
- Acts as a synthesizable stand-in for physical memory in core-level simulation.
- Also serves as a latency-injection endpoint for stressing the control FSM.

Parameters:
- DEPTH, 256, number of 32-bit words stored; must be a power of two.
- LATENCY, 3, cycles from request acceptance to mem_resp; legal range 1..15.

Ports:
- clk  input  1  system clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- mem_read  input  1  read request; held by initiator until mem_resp
- mem_write  input  1  write request; held by initiator until mem_resp
- mem_address  input  32  byte address; bits [1:0] ignored
- mem_wdata  input  32  write data
- mem_byte_enable  input  4  per-byte write enable; bit i covers wdata[8i+7:8i]
- mem_resp  output  1  one-cycle completion pulse
- mem_rdata  output  32  read data; valid only while mem_resp=1, else 0
- proto_err  output  1  sticky protocol-error flag

Behaviour:
- Reset (rst=1 at an edge):
  - state<=IDLE, counter<=0.
  - mem_resp=0, mem_rdata=0, proto_err=0.
  - All storage words<=0.
  - Reset dominates every other event.
- Word index = mem_address[log2(DEPTH)+1:2]. Higher bits are discarded, so addresses wrap modulo DEPTH words.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - If mem_read|mem_write at an edge: latch address, wdata, byte_enable and op into internal registers.
  - Latch rdata_q<=storage[index] (pre-write contents).
  - Load counter<=LATENCY-1.
  - Go to WAIT if LATENCY>1, else go to RESP.
  - With no request, stay in IDLE.
- WAIT: decrement counter each edge; when counter==1, go to RESP. Inputs are ignored, and latched values are used.
- RESP:
  - mem_resp=1 for exactly this one cycle.
  - mem_rdata=rdata_q if latched op included a read, else 0.
  - On the edge leaving RESP:
    - If latched op included a write, commit storage[index] byte-wise per latched byte_enable.
    - Go to IDLE.
- Latency: request first seen high at cycle 0 gives mem_resp high at cycle LATENCY exactly.
- Back-to-back requests:
  - The initiator drops or changes requests on the edge ending the resp cycle.
  - If mem_read/mem_write are still high in the first IDLE cycle, that is a new request and is accepted.
  - Minimum spacing between resp pulses is therefore LATENCY+1 cycles.
- Simultaneous mem_read and mem_write at acceptance:
  - proto_err<=1 (sticky until rst).
  - The write is committed.
  - mem_rdata returns the pre-write word.
- Input changes during WAIT/RESP have no effect. Latched values govern the transaction; proto_err is not set for this.
- mem_byte_enable=0 on a write: no storage change; mem_resp still pulses.
- Reset mid-transaction (WAIT or RESP): abort; no write committed; no resp pulse; return to IDLE next cycle.
- Read-after-write to the same word in the next transaction returns the newly written data.

Test Plan:
- LATENCY=3, write 0xDEADBEEF, be=4'b1111 to 0x40; then read 0x40 -> mem_resp exactly 3 cycles after each request; read returns 0xDEADBEEF; mem_rdata=0 outside resp cycle.
- Word at 0x40 = 0xDEADBEEF; write 0x11223344 with be=4'b0101 -> subsequent read of 0x40 returns 0xDE22BE44.
- DEPTH=256: write 0xA5A5A5A5 to 0x404; read 0x004 -> returns 0xA5A5A5A5 (wrap); read 0x006 also returns it (bits [1:0] ignored).
- Assert mem_read and mem_write together at 0x80 (old 0, wdata 0x5) -> resp returns 0; proto_err=1 and stays 1; later read returns 0x5; rst clears proto_err.
- Write request 0x10 with data 0x77; pulse rst during WAIT -> no mem_resp; later read of 0x10 returns 0.
- LATENCY=1: hold mem_read high continuously -> mem_resp pulses every 2 cycles (cycles 1, 3, 5, ...), each with current data.
